// File: rtl/multi_mode_game_counter.sv
// Up/down game counter with winner/loser pulses, score tallies and a game-over restart cycle.
// Optional GAMEOVER_ACK_EN adds game_ack: OVER is held until acknowledged.
module multi_mode_game_counter #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SCORE_W     = 4,
    parameter int unsigned SCORE_LIMIT = 15,
    parameter int unsigned STEP_SMALL  = 1,
    parameter int unsigned STEP_LARGE  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [1:0]         control,
    input  logic               INIT,
    input  logic [WIDTH-1:0]   initial_value,
`ifdef GAMEOVER_ACK_EN
    input  logic               game_ack,
`endif
    output logic [WIDTH-1:0]   counter_out,
    output logic               WINNER,
    output logic               LOSER,
    output logic [SCORE_W-1:0] winner_count,
    output logic [SCORE_W-1:0] loser_count,
    output logic               GAMEOVER,
    output logic [1:0]         WHO
);

    typedef enum logic {StPlay, StOver} state_e;

    localparam logic [WIDTH-1:0]   StepS = WIDTH'(STEP_SMALL);
    localparam logic [WIDTH-1:0]   StepL = WIDTH'(STEP_LARGE);
    localparam logic [WIDTH-1:0]   AllOnes = '1;
    localparam logic [SCORE_W-1:0] Limit = SCORE_W'(SCORE_LIMIT);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic               win_q, win_d, lose_q, lose_d;
    logic [SCORE_W-1:0] wcnt_q, wcnt_d, lcnt_q, lcnt_d;
    logic [1:0]         who_q, who_d;
    logic [WIDTH-1:0]   step;
    logic               restart;

`ifdef GAMEOVER_ACK_EN
    assign restart = game_ack;
`else
    assign restart = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StPlay;
            cnt_q   <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            wcnt_q  <= '0;
            lcnt_q  <= '0;
            who_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            wcnt_q  <= wcnt_d;
            lcnt_q  <= lcnt_d;
            who_q   <= who_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = 1'b0;
        lose_d  = 1'b0;
        wcnt_d  = wcnt_q;
        lcnt_d  = lcnt_q;
        who_d   = who_q;
        step    = control[0] ? StepL : StepS;
        unique case (state_q)
            StPlay: begin
                if (INIT) begin
                    cnt_d = initial_value;
                end else if (en) begin
                    cnt_d = control[1] ? cnt_q - step : cnt_q + step;
                end
                // Only a load or a step can land on a pulse value; holds never re-pulse.
                if (INIT || en) begin
                    win_d  = (cnt_d == AllOnes);
                    lose_d = (cnt_d == '0);
                end
                if (win_d) begin
                    wcnt_d = wcnt_q + SCORE_W'(1);
                    if (wcnt_d == Limit) begin
                        state_d = StOver;
                        who_d   = 2'b10;
                    end
                end
                if (lose_d) begin
                    lcnt_d = lcnt_q + SCORE_W'(1);
                    if (lcnt_d == Limit) begin
                        state_d = StOver;
                        who_d   = 2'b01;
                    end
                end
            end
            StOver: begin
                if (restart) begin
                    state_d = StPlay;
                    cnt_d   = INIT ? initial_value : '0;
                    wcnt_d  = '0;
                    lcnt_d  = '0;
                    who_d   = 2'b00;
                end
            end
            default: state_d = StPlay;
        endcase
    end

    always_comb begin
        counter_out  = cnt_q;
        WINNER       = win_q;
        LOSER        = lose_q;
        winner_count = wcnt_q;
        loser_count  = lcnt_q;
        GAMEOVER     = (state_q == StOver);
        WHO          = who_q;
    end

endmodule
